// File: rtl/seg7_pkg.sv
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Seven-segment constants and mode encoding for the BCD tracker.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    // Active-low patterns, bit0..6 = segments a..g, bit7 = dp (kept dark)
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DIGIT [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_MIN = 1'b1
    } mode_e;

endpackage : seg7_pkg

`default_nettype wire

// File: rtl/bcd_seg8.sv
// ============================================================================
//  Module   : bcd_seg8
//  Purpose  : One BCD digit to 8-bit active-low segment pattern; non-BCD blanks.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_seg8
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
        endcase
    end

endmodule : bcd_seg8

`default_nettype wire

// File: rtl/bcd_minmax_tracker.sv
// ============================================================================
//  Module   : bcd_minmax_tracker
//  Purpose  : Registered BCD min/max comparator with running extreme, debounced
//             mode button and four seven-segment displays.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_minmax_tracker
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 1,
    parameter int DEB_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  sample,
    input  logic                  clr,
    input  logic                  btn_n,
    output logic [8*DIGITS-1:0]   seg_a,
    output logic [8*DIGITS-1:0]   seg_b,
    output logic [8*DIGITS-1:0]   seg_r,
    output logic [8*DIGITS-1:0]   seg_x,
    output logic                  mode,
    output logic                  ext_valid,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    // Packed BCD orders like unsigned binary; ties select the first operand.
    function automatic logic [W-1:0] pick(input mode_e m, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
        if (m == MODE_MAX) return (x >= y) ? x : y;
        else               return (x <= y) ? x : y;
    endfunction

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             toggle_q, toggle_d;
    logic             armed_q, armed_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     ext_q, ext_d;
    mode_e            mode_q, mode_d;
    logic             ext_valid_q, ext_valid_d;
    logic             err_q, err_d;

    logic             in_ok;
    logic [W-1:0]     pair_in;
    logic [W-1:0]     pair_q;
    logic [8*DIGITS-1:0] seg_x_raw;

    // Syncs reset to the "pressed" level and presses only count once the
    // released level has been seen, so a button held through reset is ignored.
    always_comb begin
        sync1_d  = btn_n;
        sync2_d  = sync1_q;
        armed_d  = armed_q | sync2_q;
        deb_d    = deb_q;
        cnt_d    = '0;
        toggle_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                deb_d    = sync2_q;
                toggle_d = armed_q & ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        in_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) in_ok = 1'b0;
        end
    end

    assign pair_in = pick(mode_q, a, b);
    assign pair_q  = pick(mode_q, a_q, b_q);

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        ext_d       = ext_q;
        mode_d      = mode_q;
        ext_valid_d = ext_valid_q;
        err_d       = err_q;
        if (sample && in_ok) begin
            a_d = a;
            b_d = b;
        end
        if (clr) begin
            ext_valid_d = 1'b0;
            err_d       = 1'b0;
        end else if (toggle_q) begin
            mode_d      = (mode_q == MODE_MAX) ? MODE_MIN : MODE_MAX;
            ext_valid_d = 1'b0;
            if (sample && !in_ok) err_d = 1'b1;
        end else if (sample) begin
            if (!in_ok) begin
                err_d = 1'b1;
            end else if (!ext_valid_q) begin
                ext_d       = pair_in;
                ext_valid_d = 1'b1;
            end else begin
                ext_d = pick(mode_q, ext_q, pair_in);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_q       <= 1'b1;
            cnt_q       <= '0;
            toggle_q    <= 1'b0;
            armed_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            ext_q       <= '0;
            mode_q      <= MODE_MAX;
            ext_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            cnt_q       <= cnt_d;
            toggle_q    <= toggle_d;
            armed_q     <= armed_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ext_q       <= ext_d;
            mode_q      <= mode_d;
            ext_valid_q <= ext_valid_d;
            err_q       <= err_d;
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_seg8 u_seg_a (.bcd(a_q[4*d +: 4]),    .seg(seg_a[8*d +: 8]));
        bcd_seg8 u_seg_b (.bcd(b_q[4*d +: 4]),    .seg(seg_b[8*d +: 8]));
        bcd_seg8 u_seg_r (.bcd(pair_q[4*d +: 4]), .seg(seg_r[8*d +: 8]));
        bcd_seg8 u_seg_x (.bcd(ext_q[4*d +: 4]),  .seg(seg_x_raw[8*d +: 8]));
    end

    assign seg_x     = ext_valid_q ? seg_x_raw : {DIGITS{SEG_BLANK}};
    assign mode      = mode_q;
    assign ext_valid = ext_valid_q;
    assign err       = err_q;

endmodule : bcd_minmax_tracker

`default_nettype wire

// File: tb/tb_bcd_minmax_tracker.sv
// ============================================================================
//  Module   : tb_bcd_minmax_tracker
//  Purpose  : Self-checking scoreboard bench for bcd_minmax_tracker (2 digits).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_minmax_tracker;

    localparam int D   = 2;
    localparam int DEB = 4;

    logic          clk = 1'b0;
    logic          rst_n, sample, clr, btn_n;
    logic [7:0]    a, b;
    logic [15:0]   seg_a, seg_b, seg_r, seg_x;
    logic          mode, ext_valid, err;

    always #5 clk = ~clk;

    bcd_minmax_tracker #(.DIGITS(D), .DEB_CYCLES(DEB)) u_dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sample(sample), .clr(clr),
        .btn_n(btn_n), .seg_a(seg_a), .seg_b(seg_b), .seg_r(seg_r),
        .seg_x(seg_x), .mode(mode), .ext_valid(ext_valid), .err(err)
    );

    typedef struct {
        logic [15:0] sa, sb, sr, sx;
        logic        md, ev, er;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic [7:0] m_a, m_b, m_ext;
    logic       m_mode, m_ev, m_err;

    task automatic check_val(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic [3:0] n);
        case (n)
            4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
            4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
            4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
            4'd9: return 8'h90;  default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [15:0] disp(input logic [7:0] v);
        return {enc(v[7:4]), enc(v[3:0])};
    endfunction

    function automatic logic [7:0] sel(input logic mn, input logic [7:0] x,
                                       input logic [7:0] y);
        if (mn) return (x <= y) ? x : y;
        return (x >= y) ? x : y;
    endfunction

    function automatic bit is_bcd(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    task automatic model_reset();
        m_a = '0; m_b = '0; m_ext = '0;
        m_mode = 1'b0; m_ev = 1'b0; m_err = 1'b0;
        sb_q.delete();
    endtask

    // One clock: drive inputs, advance the model, push the expectation,
    // then pop and compare once the DUT has taken the edge.
    task automatic cycle(input bit s, input logic [7:0] av, input logic [7:0] bv,
                         input bit c, input bit tog);
        exp_t e;
        logic [7:0] pr;
        bit ok;
        sample = s; a = av; b = bv; clr = c;
        ok = is_bcd(av) && is_bcd(bv);
        pr = sel(m_mode, av, bv);
        if (s && ok) begin m_a = av; m_b = bv; end
        if (c) begin
            m_ev = 1'b0; m_err = 1'b0;
        end else if (tog) begin
            m_mode = ~m_mode; m_ev = 1'b0;
            if (s && !ok) m_err = 1'b1;
        end else if (s) begin
            if (!ok)        m_err = 1'b1;
            else if (!m_ev) begin m_ext = pr; m_ev = 1'b1; end
            else            m_ext = sel(m_mode, m_ext, pr);
        end
        e.sa = disp(m_a); e.sb = disp(m_b);
        e.sr = disp(sel(m_mode, m_a, m_b));
        e.sx = m_ev ? disp(m_ext) : 16'hFFFF;
        e.md = m_mode; e.ev = m_ev; e.er = m_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        sample = 1'b0; clr = 1'b0;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 16'd0, 16'd1);
        end else begin
            e = sb_q.pop_front();
            check_val("seg_a", seg_a, e.sa);
            check_val("seg_b", seg_b, e.sb);
            check_val("seg_r", seg_r, e.sr);
            check_val("seg_x", seg_x, e.sx);
            check_val("mode", {15'd0, mode}, {15'd0, e.md});
            check_val("ext_valid", {15'd0, ext_valid}, {15'd0, e.ev});
            check_val("err", {15'd0, err}, {15'd0, e.er});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    // Hold the button low; toggle lands on edge 2 + DEB + 1
    task automatic press(input bit s7, input logic [7:0] av, input logic [7:0] bv);
        btn_n = 1'b0;
        for (int i = 0; i < DEB + 2; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        cycle(s7, av, bv, 1'b0, 1'b1);
    endtask

    task automatic release_btn();
        btn_n = 1'b1;
        idle(DEB + 6);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_seg_a"}, seg_a, 16'hC0C0);
        check_val({tag, "_seg_b"}, seg_b, 16'hC0C0);
        check_val({tag, "_seg_r"}, seg_r, 16'hC0C0);
        check_val({tag, "_seg_x"}, seg_x, 16'hFFFF);
        check_val({tag, "_mode"}, {15'd0, mode}, 16'd0);
        check_val({tag, "_ev"}, {15'd0, ext_valid}, 16'd0);
        check_val({tag, "_err"}, {15'd0, err}, 16'd0);
    endtask

    initial begin
        logic [7:0] av, bv;
        rst_n = 1'b0; sample = 1'b0; clr = 1'b0; a = '0; b = '0; btn_n = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        idle(4);

        // MAX then MIN on the same pair, and a tie
        cycle(1'b1, 8'h37, 8'h52, 1'b0, 1'b0);
        check_val("r_max_lit", seg_r, 16'h92A4);
        press(1'b0, 8'h00, 8'h00);
        check_val("r_min_lit", seg_r, 16'hB0F8);
        release_btn();
        cycle(1'b1, 8'h44, 8'h44, 1'b0, 1'b0);
        check_val("r_tie_lit", seg_r, 16'h9999);

        // Back to MAX, running extreme
        press(1'b0, 8'h00, 8'h00);
        release_btn();
        cycle(1'b1, 8'h12, 8'h05, 1'b0, 1'b0);
        check_val("x1_lit", seg_x, 16'hF9A4);
        cycle(1'b1, 8'h03, 8'h09, 1'b0, 1'b0);
        check_val("x2_lit", seg_x, 16'hF9A4);
        cycle(1'b1, 8'h40, 8'h41, 1'b0, 1'b0);
        check_val("x3_lit", seg_x, 16'h99F9);

        // Short glitch must not toggle
        btn_n = 1'b0;
        idle(DEB - 1);
        btn_n = 1'b1;
        idle(DEB + 6);
        check_val("glitch_mode", {15'd0, mode}, 16'd0);

        // Invalid BCD, then clear
        cycle(1'b1, 8'h3A, 8'h11, 1'b0, 1'b0);
        check_val("err_lit", {15'd0, err}, 16'd1);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check_val("clr_x_lit", seg_x, 16'hFFFF);

        // clr together with sample
        cycle(1'b1, 8'h21, 8'h19, 1'b0, 1'b0);
        cycle(1'b1, 8'h63, 8'h98, 1'b1, 1'b0);
        check_val("clr_smp_a", seg_a, 16'h82B0);

        // toggle together with sample, then first extreme of new mode
        cycle(1'b1, 8'h55, 8'h70, 1'b0, 1'b0);
        press(1'b1, 8'h81, 8'h27);
        check_val("tog_smp_b", seg_b, 16'hA4F8);
        release_btn();
        cycle(1'b1, 8'h33, 8'h06, 1'b0, 1'b0);

        // Random mix in MIN mode, with occasional bad nibbles and clears
        for (int i = 0; i < 24; i++) begin
            av = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            bv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if (i % 7 == 3) av[3:0] = 4'hC;
            if (i % 5 == 2) bv = av;
            cycle(1'b1, av, bv, (i % 9 == 5), 1'b0);
        end

        // Asynchronous reset with the button held through its release
        btn_n = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("arst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(DEB + 8);
        release_btn();
        press(1'b0, 8'h00, 8'h00);
        check_val("post_rst_mode", {15'd0, mode}, 16'd1);
        release_btn();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_bcd_minmax_tracker

`default_nettype wire

// File: doc/bcd_minmax_tracker.md
# bcd_minmax_tracker

Registered, parametrised BCD min/max comparator with a running-extreme tracker and four seven-segment outputs. Operands A and B are captured on a sample strobe, displayed, and compared. A debounced push-button toggles between MAX and MIN mode. A fourth display holds the running max/min of all accepted samples since the last clear or mode change. The block sits between the switch/button inputs and the board HEX displays.

## Interface
- `DIGITS`, default 1: BCD digits per operand; operand width is 4·DIGITS.
- `DEB_CYCLES`, default 4: number of consecutive stable synchronised cycles needed to accept a button level change; must be ≥ 1.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `a`  in  4·DIGITS: operand A, packed BCD, digit 0 in the LSBs.
- `b`  in  4·DIGITS: operand B, packed BCD.
- `sample`  in  1: one-cycle capture strobe.
- `clr`  in  1: synchronous clear of the running extreme and the error flag.
- `btn_n`  in  1: raw mode button, active-low and asynchronous to `clk`.
- `seg_a`, `seg_b`, `seg_r`, `seg_x`  out  8·DIGITS each: segment patterns for A, B, the pair result and the running extreme; 8 bits per digit.
- `mode`  out  1: current mode, 0 = MAX, 1 = MIN.
- `ext_valid`  out  1: high when `seg_x` holds a valid extreme.
- `err`  out  1: sticky flag, set by a sample containing a non-BCD digit.

## Operation
- **Segment encoding**
  - Active-low; bit0..6 map to segments a..g; bit7 is dp and is always 1.
  - Digits 0–9 encode as C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex).
  - Blank is FF. Nibbles A–F also encode as FF.
- **Button path**
  - `btn_n` passes through a 2-flop synchroniser.
  - A counter counts consecutive cycles in which the synchronised level differs from the debounced level. Any cycle where they agree resets the counter to 0.
  - When the count reaches `DEB_CYCLES`, the debounced level flips.
  - A debounced 1→0 transition (a press) generates a one-cycle `toggle` pulse. Release generates nothing.
- **Mode**
  - On `toggle`, `mode` inverts and `ext_valid` clears.
- **Sample**
  - On an accepted `sample`, A and B are registered into `a_q` and `b_q`.
  - If any nibble of A or B is greater than 9, `err` is set and `a_q`, `b_q` and the extreme are left unchanged.
- **Comparison**
  - Packed BCD is compared as an unsigned binary word; BCD ordering is preserved under this comparison.
  - `seg_r` shows max(`a_q`, `b_q`) in MAX mode and min(`a_q`, `b_q`) in MIN mode, from the current `mode`.
  - On a tie, A is selected.
- **Running extreme**
  - On a valid sample with `ext_valid` = 0: load the pair result computed from the incoming A, B and the current `mode`, then set `ext_valid`.
  - On a valid sample with `ext_valid` = 1: update `ext` to max/min(`ext`, incoming pair result) according to the current mode.
  - While `ext_valid` = 0, `seg_x` is blank.
- **Priority in a single cycle:** `clr` > `toggle` > `sample`.
  - `clr` together with `sample`: `ext_valid` = 0 and `err` = 0; operands are still captured if they are valid BCD.
  - `toggle` together with `sample`: `ext_valid` = 0, `mode` inverts, and operands are captured. The extreme is not loaded, so the first extreme in the new mode comes from the next sample.

## Timing
- **Reset values:** `a_q`, `b_q` and `ext` = 0; `seg_a`, `seg_b` and `seg_r` show all "0" (C0 per digit); `seg_x` = all FF; `mode` = 0, `ext_valid` = 0, `err` = 0; debounced level = 1; counter = 0.
- **Sample latency:** `sample` high in cycle N gives new `seg_a`, `seg_b`, `seg_r`, `seg_x` and `err` in cycle N+1. Segment outputs are combinational decodes of registered state.
- **Mode-change latency:** `seg_r` follows a `mode` change combinationally, in the same cycle.
- **Button latency:** if `btn_n` falls and stays low, `mode` inverts exactly 2 + `DEB_CYCLES` + 1 edges later. A low pulse shorter than `DEB_CYCLES` synchronised cycles never toggles.
- **Reset mid-operation:** reset takes effect asynchronously. Any debounce in progress is discarded, and a button held through reset release does not toggle.

## Structure
- **Shared package (`seg7_pkg`):** segment constants (SEG_BLANK, digit table) and the MODE_MAX/MODE_MIN encodings.
- **Sub-module `bcd_seg8`:** one-digit BCD to 8-bit active-low decoder, instantiated 4·DIGITS times via generate.
- **Kept inline:** debounce and toggle logic.

## Test plan
- **Reset values:** assert reset → all `seg_*` digits C0, except `seg_x` = FF; `mode` = 0; `err` = 0.
- **Basic MAX/MIN and ties** (DIGITS = 2):
  - Sample a = 0x37, b = 0x52 → `seg_r` = {92, A4} in cycle N+1.
  - Press the button → `seg_r` = {B0, F8}.
  - Tie a = b = 0x44 → `seg_r` shows 44.
- **Running extreme (MAX):** samples (12, 05), (03, 09), (40, 41) → `seg_x` shows 12, then 12, then 41; `ext_valid` = 1 from the first sample.
- **Debounce** (DEB_CYCLES = 4):
  - A 3-cycle low glitch → `mode` unchanged.
  - A held press → `mode` flips at edge 7 and `ext_valid` = 0.
  - Release → no change.
- **Invalid BCD:** sample a = 0x3A → `err` = 1 and operands/extreme unchanged; `clr` → `err` = 0 and `seg_x` = FF.
- **Simultaneous events:**
  - `clr` + valid `sample` in one cycle → operands updated, `ext_valid` = 0.
  - `toggle` + `sample` in one cycle → `ext_valid` = 0 and `mode` inverted.
